reaction_timer: RTL
===================

# reaction_timer

Reaction-time measurement controller that drives the 4-digit seven-segment display stage directly. From IDLE it waits a pseudo-random delay after a start press, lights a stimulus LED, and counts milliseconds until the stop press. It presents the result as a 14-bit binary value plus a greeting flag: `o_bin` → `i_bin`, `o_greeting` → `i_greeting` of the display stage. Button inputs arrive as debounced single-cycle pulses from the existing debounce/edge-detect blocks.

## Interface
- `TICKS_PER_MS`, 100_000: clock cycles per millisecond (100 MHz clock).
- `MIN_DELAY_MS`, 2000: minimum stimulus delay in ms.
- `DELAY_MASK`, 8191: mask applied to the LFSR value for the random delay part.
- `MAX_REACT_MS`, 1000: timeout and saturation value for the reaction count.
- One clock; reset is synchronous and active-high (`i_clk`, `i_rst`).
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_clear`  in  1  one-cycle pulse; returns to IDLE.
- `i_start`  in  1  one-cycle pulse; begins a trial.
- `i_stop`  in  1  one-cycle pulse; user reaction.
- `o_led`  out  1  stimulus LED, active high.
- `o_bin`  out  14  value to display, 0..9999.
- `o_greeting`  out  1  high in IDLE only; display shows "HI".
- `o_done`  out  1  high while in DONE (result frozen).

## Operation
- **States:** IDLE, WAIT, REACT, DONE.
- **Priority:** `i_clear` overrides `i_start` and `i_stop` in every state. A clear moves to IDLE and zeroes all counters.
- **LFSR:**
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11.
  - Reset seed 16'hACE1. Advances every cycle in all states.
  - Never all-zero.
- **IDLE:**
  - Outputs: `o_greeting`=1, `o_bin`=0, `o_led`=0, `o_done`=0.
  - On `i_start`: load delay D = `MIN_DELAY_MS` + (lfsr & `DELAY_MASK`), using the LFSR value present in the sampling cycle. Clear the tick and ms counters, then go to WAIT.
- **WAIT:**
  - Outputs: `o_greeting`=0, `o_bin`=0, `o_led`=0.
  - A tick counter counts 0..`TICKS_PER_MS`-1; each wrap decrements the delay counter.
  - When D ms have elapsed: go to REACT, `o_led`=1, ms count cleared.
  - On `i_stop` (cheat): go to DONE with the result latched at 9999.
  - `i_start` is ignored.
- **REACT:**
  - `o_led`=1; `o_bin` shows the live ms count.
  - On `i_stop`: latch the count, go to DONE.
  - When the count reaches `MAX_REACT_MS`: latch `MAX_REACT_MS`, go to DONE (timeout).
  - `i_start` is ignored.
- **DONE:**
  - Outputs: `o_led`=0, `o_done`=1, `o_bin` = latched result.
  - `i_start` and `i_stop` are ignored; only `i_clear` (or reset) exits.
- **Width rules:**
  - Delay counter width is sized for `MIN_DELAY_MS` + `DELAY_MASK`.
  - The ms counter saturates at `MAX_REACT_MS` and never wraps.
  - `o_bin` is never greater than 9999.

## Timing
- **Reset:** state IDLE, `o_led`=0, `o_bin`=0, `o_greeting`=1, `o_done`=0, LFSR=16'hACE1.
- **Registered outputs:** all outputs are registered. They change on the same edge as the state change that causes them.
- **Start:** `i_start` sampled at edge k puts the block in WAIT from edge k.
- **Stimulus onset:** `o_led` rises at edge k + D·`TICKS_PER_MS`.
- **Reaction count:** with REACT entered at edge r, `i_stop` sampled at edge r+n gives a result of floor(n / `TICKS_PER_MS`). `o_done` and the result appear from edge r+n.
- **Timeout:** at edge r + `MAX_REACT_MS`·`TICKS_PER_MS`, the block enters DONE with `MAX_REACT_MS`.
  - An `i_stop` on that same edge yields the same value.
- **Delay expiry vs stop:** if `i_stop` and delay expiry fall on the same edge in WAIT, stop wins and the result is a cheat (9999).
- **Simultaneous start and stop in IDLE:** start wins and stop is ignored.
- **Reset mid-trial:** IDLE values appear at the next edge, from any state.

## Test plan
Parameters for all scenarios: `TICKS_PER_MS`=10, `MIN_DELAY_MS`=5, `DELAY_MASK`=0, `MAX_REACT_MS`=1000.

1. **Reset:** reset for 3 cycles, then release → `o_greeting`=1, `o_bin`=0, `o_led`=0, `o_done`=0.
2. **Normal reaction:** `i_start` at edge k → `o_led`=1 at edge k+50. Then `i_stop` 1234 cycles later → `o_bin`=123, `o_done`=1, `o_led`=0.
3. **Cheat:** `i_start`, then `i_stop` 20 cycles later → `o_bin`=9999, `o_done`=1, `o_led` stays 0. A further `i_start` is ignored.
4. **Timeout:** `i_start`, no stop → DONE 10000 cycles after LED onset with `o_bin`=1000. A stop on that exact edge also gives 1000.
5. **Clear priority:** `i_clear` together with `i_stop` during REACT → IDLE, `o_greeting`=1, `o_bin`=0. A new trial then works normally.
6. **Random delay:** with `DELAY_MASK`=8191, `MIN_DELAY_MS`=5, the LED delay in cycles equals 10·(5 + (lfsr & 8191)), using a reference-model LFSR sampled at the start edge.

Source files
------------

// File: rtl/reaction_timer.sv
// Reaction-time controller: random pre-stimulus delay, LED onset, millisecond
// reaction count, and a 14-bit result/greeting feed for the seven-segment stage.
module reaction_timer #(
    parameter int TICKS_PER_MS = 100_000,
    parameter int MIN_DELAY_MS = 2000,
    parameter int DELAY_MASK   = 8191,
    parameter int MAX_REACT_MS = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_start,
    input  logic        i_stop,
    output logic        o_led,
    output logic [13:0] o_bin,
    output logic        o_greeting,
    output logic        o_done
);

    localparam int TW = $clog2(TICKS_PER_MS + 1);
    localparam int DW = $clog2(MIN_DELAY_MS + DELAY_MASK + 1);
    localparam int MW = $clog2(MAX_REACT_MS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);
    localparam logic [MW-1:0] MS_MAX    = MW'(MAX_REACT_MS);
    localparam logic [13:0]   CHEAT_VAL = 14'd9999;
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REACT,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [15:0]   lfsr;
    logic          lfsr_fb;
    logic [TW-1:0] tick, tick_n;
    logic [DW-1:0] delay, delay_n;
    logic [DW-1:0] delay_load;
    logic [MW-1:0] ms, ms_n;
    logic [MW-1:0] ms_inc;
    logic [13:0]   result, result_n;
    logic          tick_wrap;
    logic          led_n;
    logic          greeting_n;
    logic          done_n;
    logic [13:0]   bin_n;

    // Fibonacci taps 16,14,13,11; a nonzero seed keeps it off the all-zero lock-up state.
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign delay_load = DW'(MIN_DELAY_MS + (int'(lfsr) & DELAY_MASK));
    assign tick_wrap  = (tick == TICK_LAST);
    assign ms_inc     = ms + MW'(1);

    always_comb begin
        state_n  = state;
        tick_n   = tick;
        delay_n  = delay;
        ms_n     = ms;
        result_n = result;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    delay_n = delay_load;
                    tick_n  = '0;
                    ms_n    = '0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                tick_n = tick_wrap ? '0 : tick + TW'(1);
                if (tick_wrap) begin
                    delay_n = delay - DW'(1);
                end
                // A stop landing on the expiry edge still counts as a cheat.
                if (i_stop) begin
                    state_n  = S_DONE;
                    result_n = CHEAT_VAL;
                end else if (tick_wrap && delay <= DW'(1)) begin
                    state_n = S_REACT;
                    tick_n  = '0;
                    ms_n    = '0;
                end
            end
            S_REACT: begin
                tick_n = tick_wrap ? '0 : tick + TW'(1);
                if (tick_wrap) begin
                    ms_n = ms_inc;
                end
                if (i_stop || (tick_wrap && ms_inc == MS_MAX)) begin
                    state_n  = S_DONE;
                    result_n = 14'(ms_n);
                end
            end
            S_DONE: begin
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (i_clear) begin
            state_n  = S_IDLE;
            tick_n   = '0;
            delay_n  = '0;
            ms_n     = '0;
            result_n = '0;
        end
    end

    // Outputs are derived from the next state so they switch on the same edge as the state.
    always_comb begin
        led_n      = (state_n == S_REACT);
        greeting_n = (state_n == S_IDLE);
        done_n     = (state_n == S_DONE);
        bin_n      = '0;
        case (state_n)
            S_REACT: bin_n = 14'(ms_n);
            S_DONE:  bin_n = result_n;
            default: bin_n = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            lfsr       <= LFSR_SEED;
            tick       <= '0;
            delay      <= '0;
            ms         <= '0;
            result     <= '0;
            o_led      <= 1'b0;
            o_bin      <= '0;
            o_greeting <= 1'b1;
            o_done     <= 1'b0;
        end else begin
            state      <= state_n;
            lfsr       <= {lfsr[14:0], lfsr_fb};
            tick       <= tick_n;
            delay      <= delay_n;
            ms         <= ms_n;
            result     <= result_n;
            o_led      <= led_n;
            o_bin      <= bin_n;
            o_greeting <= greeting_n;
            o_done     <= done_n;
        end
    end

endmodule
